// File: rtl/gcd_lcm_unit.sv
// GCD (binary Stein reduction) or LCM via (a/gcd)*b, with an HLS-style start/idle/ready/done handshake.
// The divider and the multiplier each run for exactly WIDTH cycles and reuse the q register.
module gcd_lcm_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic [2*WIDTH-1:0]   ap_return
);

    typedef enum logic [3:0] {
        IDLE, ZCHK, SHIFT, AODD, LOOP, FIX, DIV, MUL, DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     a_in, b_in, x, y, g, q, rem;
    logic [CW-1:0]        k, cnt;
    logic                 mode_r;
    logic [2*WIDTH-1:0]   result, acc, mc;

    logic [WIDTH-1:0]     g_shift, rem_nx;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_lt;
    logic [2*WIDTH-1:0]   acc_nx;

    always_comb begin
        g_shift = x << k;
        rem_sh  = {rem, q[WIDTH-1]};
        rem_lt  = rem_sh < {1'b0, g};
        rem_nx  = rem_lt ? rem_sh[WIDTH-1:0] : (rem_sh[WIDTH-1:0] - g);
        acc_nx  = acc + (q[0] ? mc : '0);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (ap_start) state_nx = ZCHK;
            ZCHK:  state_nx = (x == '0 || y == '0) ? DONE : SHIFT;
            SHIFT: if (x[0] || y[0]) state_nx = AODD;
            AODD:  if (x[0]) state_nx = LOOP;
            LOOP:  if (y == '0) state_nx = FIX;
            FIX:   state_nx = mode_r ? DIV : DONE;
            DIV:   if (cnt == LAST) state_nx = MUL;
            MUL:   if (cnt == LAST) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ap_idle = (state == IDLE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_in      <= '0;
            b_in      <= '0;
            x         <= '0;
            y         <= '0;
            g         <= '0;
            q         <= '0;
            rem       <= '0;
            k         <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            result    <= '0;
            acc       <= '0;
            mc        <= '0;
            ap_ready  <= 1'b0;
            ap_done   <= 1'b0;
            ap_return <= '0;
        end else begin
            ap_ready <= 1'b0;
            ap_done  <= 1'b0;
            case (state)
                IDLE: if (ap_start) begin
                    a_in     <= a;
                    b_in     <= b;
                    x        <= a;
                    y        <= b;
                    mode_r   <= mode;
                    k        <= '0;
                    ap_ready <= 1'b1;
                end
                ZCHK: if (x == '0 || y == '0)
                    result <= mode_r ? '0 : {{WIDTH{1'b0}}, x | y};
                SHIFT: if (!x[0] && !y[0]) begin
                    x <= x >> 1;
                    y <= y >> 1;
                    k <= k + CW'(1);
                end
                AODD: if (!x[0]) x <= x >> 1;
                LOOP: if (y != '0) begin
                    if (!y[0])      y <= y >> 1;
                    else if (x > y) begin
                        x <= y;
                        y <= x - y;
                    end else        y <= y - x;
                end
                FIX: begin
                    g      <= g_shift;
                    result <= {{WIDTH{1'b0}}, g_shift};
                    q      <= a_in;
                    rem    <= '0;
                    cnt    <= '0;
                end
                // q shifts the dividend out at the top while quotient bits enter at the bottom
                DIV: begin
                    q   <= {q[WIDTH-2:0], ~rem_lt};
                    rem <= rem_nx;
                    if (cnt == LAST) begin
                        cnt <= '0;
                        acc <= '0;
                        mc  <= {{WIDTH{1'b0}}, b_in};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MUL: begin
                    acc <= acc_nx;
                    mc  <= mc << 1;
                    q   <= q >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) result <= acc_nx;
                end
                DONE: begin
                    ap_return <= result;
                    ap_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Randomised and directed bench for gcd_lcm_unit, checked against a Euclid-based reference model.
module tb_gcd_lcm_unit;

    localparam int W = 32;

    logic             ap_clk, ap_rst_n, ap_start, mode;
    logic [W-1:0]     a, b;
    logic             ap_idle, ap_ready, ap_done;
    logic [2*W-1:0]   ap_return;

    gcd_lcm_unit #(.WIDTH(W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .mode(mode),
        .a(a), .b(b), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_return(ap_return)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int unsigned checks = 0, fails = 0;

    function automatic void chk(input bit ok, input string nm,
                                input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Euclid by remainder; lcm as (a/g)*b at double width
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic m);
        logic [W-1:0]   p, r, t;
        logic [2*W-1:0] lhs, rhs;
        p = x; r = y;
        while (r != '0) begin
            t = p % r;
            p = r;
            r = t;
        end
        if (!m) return {{W{1'b0}}, p};
        if (x == '0 || y == '0) return '0;
        lhs = {{W{1'b0}}, x / p};
        rhs = {{W{1'b0}}, y};
        return lhs * rhs;
    endfunction

    typedef struct {
        logic [W-1:0]   a, b;
        logic           m;
        logic [2*W-1:0] exp;
        int unsigned    cyc;
    } job_t;

    job_t           jobs[$];
    int unsigned    cyc = 0, ready_cnt = 0, done_cnt = 0;
    bit             cap_flag = 0, busy = 0;
    logic [2*W-1:0] last_ret = '0;

    always @(posedge ap_clk) begin
        job_t j;
        cyc++;
        if (!ap_rst_n) begin
            jobs.delete();
            cap_flag = 0;
            busy     = 0;
            last_ret = '0;
        end else begin
            cap_flag = ap_start && !busy;
            if (cap_flag) begin
                j.a = a; j.b = b; j.m = mode;
                j.exp = model(a, b, mode);
                j.cyc = cyc;
                jobs.push_back(j);
                busy = 1;
            end
        end
    end

    always @(negedge ap_clk) begin
        job_t        j;
        int unsigned lat;
        if (ap_rst_n) begin
            chk(ap_ready === cap_flag, "ready_pulse", {63'b0, ap_ready}, {63'b0, cap_flag});
            if (ap_ready) ready_cnt++;
            if (ap_done) begin
                done_cnt++;
                busy = 0;
                if (jobs.size() == 0) begin
                    chk(1'b0, "spurious_done", {63'b0, ap_done}, '0);
                end else begin
                    j   = jobs.pop_front();
                    lat = cyc - j.cyc;
                    chk(ap_return === j.exp, $sformatf("result a=%h b=%h m=%0d", j.a, j.b, j.m),
                        ap_return, j.exp);
                    last_ret = j.exp;
                    if (j.a == '0 || j.b == '0)
                        chk(lat == 2, "zero_latency", 64'(lat), 64'd2);
                    else if (!j.m)
                        chk(lat <= 4*W + 10, "gcd_latency", 64'(lat), 64'(4*W + 10));
                    else
                        chk(lat >= 2*W + 2 && lat <= 6*W + 10, "lcm_latency", 64'(lat),
                            64'(6*W + 10));
                end
            end else begin
                chk(ap_return === last_ret, "return_hold", ap_return, last_ret);
            end
            chk(ap_idle === !busy, "idle", {63'b0, ap_idle}, {63'b0, !busy});
        end
    end

    task automatic wait_ready(output bit got);
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge ap_clk);
            if (ap_ready) got = 1;
        end
        if (!got) chk(1'b0, "ready_timeout", '0, 64'd1);
    endtask

    task automatic wait_done(input bit pulse_start);
        bit got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(negedge ap_clk);
            if (ap_done) got = 1;
            else if (pulse_start) ap_start = ap_idle ? 1'b0 : 1'($urandom_range(0, 1));
        end
        ap_start = 1'b0;
        if (!got) chk(1'b0, "done_timeout", '0, 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tm,
                          input logic [2*W-1:0] expv);
        int unsigned r0 = ready_cnt, d0 = done_cnt;
        bit got;
        @(negedge ap_clk);
        a = ta; b = tb_; mode = tm; ap_start = 1'b1;
        wait_ready(got);
        ap_start = 1'b0;
        wait_done(1'b0);
        chk(ap_return === expv, $sformatf("literal a=%h b=%h m=%0d", ta, tb_, tm), ap_return, expv);
        @(negedge ap_clk);
        chk(ready_cnt - r0 == 1, "ready_count", 64'(ready_cnt - r0), 64'd1);
        chk(done_cnt - d0 == 1, "done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic gen(output logic [W-1:0] ga, output logic [W-1:0] gb);
        int unsigned c;
        case ($urandom_range(0, 3))
            0: begin ga = $urandom; gb = $urandom; end
            1: begin ga = W'($urandom_range(0, 40)); gb = W'($urandom_range(0, 40)); end
            2: begin
                c  = $urandom_range(1, 1000);
                ga = W'((c * $urandom_range(1, 999)) << $urandom_range(0, 10));
                gb = W'((c * $urandom_range(1, 999)) << $urandom_range(0, 10));
            end
            default: begin ga = $urandom; gb = ga; end
        endcase
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, r0;
        bit got;
        ap_rst_n = 1'b0; ap_start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge ap_clk);
        chk(ap_idle === 1'b1, "rst_idle", {63'b0, ap_idle}, 64'd1);
        chk(ap_ready === 1'b0, "rst_ready", {63'b0, ap_ready}, 64'd0);
        chk(ap_done === 1'b0, "rst_done", {63'b0, ap_done}, 64'd0);
        chk(ap_return === '0, "rst_return", ap_return, '0);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        run_op(32'd48, 32'd18, 1'b0, 64'd6);
        run_op(32'd4, 32'd6, 1'b1, 64'd12);
        run_op(32'd21, 32'd6, 1'b1, 64'd42);
        run_op(32'd0, 32'd7, 1'b0, 64'd7);
        run_op(32'd0, 32'd7, 1'b1, 64'd0);
        run_op(32'd0, 32'd0, 1'b0, 64'd0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 64'd1);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFD00000002);
        run_op(32'h80000000, 32'h40000000, 1'b0, 64'h40000000);
        run_op(32'd97, 32'd97, 1'b1, 64'd97);
        run_op(32'd1, 32'd123456, 1'b0, 64'd1);

        // random operations with ap_start toggling while busy
        for (int n = 0; n < 30; n++) begin
            r0 = ready_cnt; d0 = done_cnt;
            @(negedge ap_clk);
            gen(a, b); mode = 1'($urandom_range(0, 1)); ap_start = 1'b1;
            wait_ready(got);
            ap_start = 1'b0;
            wait_done(1'b1);
            @(negedge ap_clk);
            chk(ready_cnt - r0 == 1 && done_cnt - d0 == 1, "busy_start_ignored",
                64'(done_cnt - d0), 64'd1);
        end

        // back-to-back with ap_start held high
        d0 = done_cnt;
        @(negedge ap_clk);
        gen(a, b); mode = 1'($urandom_range(0, 1)); ap_start = 1'b1;
        for (int n = 0; n < 15; n++) begin
            got = 0;
            for (int i = 0; i < 600 && !got; i++) begin
                @(negedge ap_clk);
                if (ap_ready) got = 1;
            end
            if (!got) chk(1'b0, "b2b_ready_timeout", '0, 64'd1);
            gen(a, b); mode = 1'($urandom_range(0, 1));
            if (n == 14) ap_start = 1'b0;
        end
        wait_done(1'b0);
        @(negedge ap_clk);
        chk(done_cnt - d0 == 15, "b2b_done_count", 64'(done_cnt - d0), 64'd15);

        // reset during the divide phase of an LCM
        @(negedge ap_clk);
        a = 32'd4; b = 32'd6; mode = 1'b1; ap_start = 1'b1;
        wait_ready(got);
        ap_start = 1'b0;
        repeat (20) @(negedge ap_clk);
        d0 = done_cnt;
        #2 ap_rst_n = 1'b0;
        #1;
        chk(ap_idle === 1'b1, "midrst_idle", {63'b0, ap_idle}, 64'd1);
        chk(ap_ready === 1'b0, "midrst_ready", {63'b0, ap_ready}, 64'd0);
        chk(ap_done === 1'b0, "midrst_done", {63'b0, ap_done}, 64'd0);
        chk(ap_return === '0, "midrst_return", ap_return, '0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (80) @(negedge ap_clk);
        chk(done_cnt == d0, "no_done_after_abort", 64'(done_cnt), 64'(d0));
        run_op(32'd12, 32'd8, 1'b0, 64'd4);

        repeat (3) @(negedge ap_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
